// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter driving a shared 4:1 data mux with a
// valid/ready downstream handshake, per-requester ack and a transfer counter.
module rr_mux_arbiter #(
  parameter int DW = 4,
  parameter int CW = 8
) (
  input  logic          iclk,
  input  logic          irst_n,
  input  logic [3:0]    ireq,
  input  logic [DW-1:0] ic0,
  input  logic [DW-1:0] ic1,
  input  logic [DW-1:0] ic2,
  input  logic [DW-1:0] ic3,
  input  logic          iready,
  output logic          ovalid,
  output logic [DW-1:0] oz,
  output logic [1:0]    osel,
  output logic [3:0]    ogrant,
  output logic [3:0]    oack,
  output logic [CW-1:0] ocount
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    sel_reg, sel_next;
  logic [1:0]    last_reg, last_next;
  logic [CW-1:0] count_reg, count_next;

  logic          xfer;
  logic [1:0]    base;
  logic [3:0]    cand;
  logic [1:0]    idx [4];
  logic [3:0]    rot_req;
  logic [1:0]    win;
  logic          any_req;
  logic [DW-1:0] data [4];

  assign xfer = (state_reg == BUSY) && iready;

  // On a transfer cycle the priority pointer already counts as updated and the
  // acked requester is masked, so a new grant can load on the same edge.
  assign base = xfer ? sel_reg : last_reg;
  assign cand = ireq & ~(xfer ? (4'b0001 << sel_reg) : 4'b0000);

  assign data[0] = ic0;
  assign data[1] = ic1;
  assign data[2] = ic2;
  assign data[3] = ic3;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      assign idx[gi]     = base + 2'(gi + 1);
      assign rot_req[gi] = cand[idx[gi]];
    end
  endgenerate

  assign any_req = |rot_req;

  always_comb begin
    win = idx[0];
    for (int i = 3; i >= 0; i--) begin
      if (rot_req[i]) win = idx[i];
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_reg <= IDLE;
      sel_reg   <= 2'd0;
      last_reg  <= 2'd3;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          sel_next   = win;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (iready) begin
          last_next  = sel_reg;
          count_next = count_reg + CW'(1);
          if (any_req) sel_next = win;
          else         state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ovalid = (state_reg == BUSY);
    osel   = sel_reg;
    ocount = count_reg;
    ogrant = ovalid ? (4'b0001 << sel_reg) : 4'b0000;
    oack   = xfer ? ogrant : 4'b0000;
    oz     = ovalid ? data[sel_reg] : '0;
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: expected grants are queued when stimulus
// is driven and popped on every valid&ready cycle.
module tb_rr_mux_arbiter;

  logic       iclk;
  logic       irst_n;
  logic [3:0] ireq;
  logic [3:0] ic0, ic1, ic2, ic3;
  logic       iready;
  logic       ovalid;
  logic [3:0] oz;
  logic [1:0] osel;
  logic [3:0] ogrant;
  logic [3:0] oack;
  logic [7:0] ocount;

  logic       ovalid2;
  logic [3:0] oz2;
  logic [1:0] osel2;
  logic [3:0] ogrant2;
  logic [3:0] oack2;
  logic [1:0] ocount2;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rr_mux_arbiter #(.DW(4), .CW(8)) dut (
    .iclk(iclk), .irst_n(irst_n), .ireq(ireq),
    .ic0(ic0), .ic1(ic1), .ic2(ic2), .ic3(ic3),
    .iready(iready), .ovalid(ovalid), .oz(oz), .osel(osel),
    .ogrant(ogrant), .oack(oack), .ocount(ocount)
  );

  rr_mux_arbiter #(.DW(4), .CW(2)) dut2 (
    .iclk(iclk), .irst_n(irst_n), .ireq(ireq),
    .ic0(ic0), .ic1(ic1), .ic2(ic2), .ic3(ic3),
    .iready(iready), .ovalid(ovalid2), .oz(oz2), .osel(osel2),
    .ogrant(ogrant2), .oack(oack2), .ocount(ocount2)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] sel, input logic [3:0] data);
    exp_t e;
    e.sel  = sel;
    e.data = data;
    sb.push_back(e);
  endtask

  // Sample at the falling edge, retire a transfer if one happens, then step
  // to just after the next rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge iclk);
    if (ovalid && iready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_xfer", {30'd0, osel}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("xfer_sel", {30'd0, osel}, {30'd0, e.sel});
        chk("xfer_data", {28'd0, oz}, {28'd0, e.data});
        chk("xfer_ack", {28'd0, oack}, {28'd0, 4'b0001 << e.sel});
      end
    end else begin
      chk("no_ack_idle_or_stall", {28'd0, oack}, 32'd0);
    end
    @(posedge iclk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge iclk);
    irst_n = 1'b0;
    #2;
    irst_n = 1'b1;
    @(posedge iclk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    irst_n = 1'b0;
    ireq   = 4'b0000;
    iready = 1'b0;
    ic0 = 4'h0; ic1 = 4'h0; ic2 = 4'h0; ic3 = 4'h0;
    #1;
    chk("rst_ovalid", {31'd0, ovalid}, 32'd0);
    chk("rst_ogrant", {28'd0, ogrant}, 32'd0);
    chk("rst_osel", {30'd0, osel}, 32'd0);
    chk("rst_ocount", {24'd0, ocount}, 32'd0);
    chk("rst_oack", {28'd0, oack}, 32'd0);
    #11;
    irst_n = 1'b1;
    @(posedge iclk);
    #1;

    // Single word from requester 0
    ireq = 4'b0001; ic0 = 4'hA; iready = 1'b1;
    push(2'd0, 4'hA);
    cycle();
    chk("t1_ovalid", {31'd0, ovalid}, 32'd1);
    chk("t1_ogrant", {28'd0, ogrant}, 32'b0001);
    chk("t1_oz", {28'd0, oz}, 32'hA);
    cycle();
    ireq = 4'b0000;
    chk("t1_idle", {31'd0, ovalid}, 32'd0);
    chk("t1_count", {24'd0, ocount}, 32'd1);

    // All four requesting: zero-bubble rotation 0,1,2,3,0
    pulse_reset();
    ic0 = 4'h1; ic1 = 4'h2; ic2 = 4'h3; ic3 = 4'h4;
    ireq = 4'b1111;
    push(2'd0, 4'h1); push(2'd1, 4'h2); push(2'd2, 4'h3);
    push(2'd3, 4'h4); push(2'd0, 4'h1);
    cycle();
    for (int k = 0; k < 5; k++) begin
      chk("t2_no_bubble", {31'd0, ovalid}, 32'd1);
      if (k == 4) ireq = 4'b0001;
      cycle();
      chk("t2_cw2_count", {30'd0, ocount2}, (k + 1) % 4);
    end
    chk("t2_idle", {31'd0, ovalid}, 32'd0);
    chk("t2_count", {24'd0, ocount}, 32'd5);
    ireq = 4'b0000;

    // Stall on requester 2 while other requests change
    pulse_reset();
    ic2 = 4'h7; ic3 = 4'h9; iready = 1'b0;
    ireq = 4'b0100;
    cycle();
    chk("t3_sel", {30'd0, osel}, 32'd2);
    ireq = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_stall_sel", {30'd0, osel}, 32'd2);
      chk("t3_stall_oz", {28'd0, oz}, 32'h7);
      chk("t3_stall_ack", {28'd0, oack}, 32'd0);
      cycle();
    end
    iready = 1'b1;
    push(2'd2, 4'h7);
    cycle();
    chk("t3_next_grant", {28'd0, ogrant}, 32'b1000);
    ireq = 4'b1000;
    push(2'd3, 4'h9);
    cycle();
    chk("t3_idle", {31'd0, ovalid}, 32'd0);
    ireq = 4'b0000;

    // Sole requester 1 streams with one idle cycle between words
    pulse_reset();
    ic1 = 4'h5; ireq = 4'b0010; iready = 1'b1;
    push(2'd1, 4'h5); push(2'd1, 4'h5); push(2'd1, 4'h5);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t4_valid_pattern", {31'd0, ovalid}, (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    ireq = 4'b0000;
    cycle();
    chk("t4_idle", {31'd0, ovalid}, 32'd0);
    chk("t4_count", {24'd0, ocount}, 32'd3);

    // Asynchronous reset in the middle of a grant
    ireq = 4'b0001; iready = 1'b0;
    cycle();
    chk("t5_busy", {31'd0, ovalid}, 32'd1);
    #3;
    irst_n = 1'b0;
    iready = 1'b1;
    #1;
    chk("t5_rst_ovalid", {31'd0, ovalid}, 32'd0);
    chk("t5_rst_ogrant", {28'd0, ogrant}, 32'd0);
    chk("t5_rst_oack", {28'd0, oack}, 32'd0);
    chk("t5_rst_count", {24'd0, ocount}, 32'd0);
    ireq = 4'b1010; iready = 1'b0;
    #1;
    irst_n = 1'b1;
    cycle();
    chk("t5_regrant_sel", {30'd0, osel}, 32'd1);
    chk("t5_regrant_ogrant", {28'd0, ogrant}, 32'b0010);
    iready = 1'b1;
    ireq = 4'b0010;
    push(2'd1, 4'h5);
    cycle();
    chk("t5_idle", {31'd0, ovalid}, 32'd0);
    ireq = 4'b0000;
    cycle();

    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Shares one 4:1 select datapath among four requesters using round-robin arbitration.
- Registers the grant and drives the 2-bit mux select.
- Presents the granted requester's data downstream with a valid/ready handshake.
- Returns a one-cycle acknowledge to the requester whose word was consumed.

Parameters:
- DW, 4, data width of each requester input and of oz
- CW, 8, width of the wrapping transfer counter ocount

Ports:
- iclk  input  1  clock; all state updates on its rising edge
- irst_n  input  1  reset, asynchronous, active-low
- ireq  input  4  per-requester request; bit n high means ic<n> holds a valid word
- ic0  input  DW  requester 0 data
- ic1  input  DW  requester 1 data
- ic2  input  DW  requester 2 data
- ic3  input  DW  requester 3 data
- iready  input  1  downstream ready
- ovalid  output  1  oz holds a granted word (registered)
- oz  output  DW  data of the granted requester
- osel  output  2  registered select index of the current grant
- ogrant  output  4  registered one-hot grant; 0 when idle
- oack  output  4  one-hot consume pulse to the granted requester
- ocount  output  CW  completed transfers, modulo 2^CW

Behaviour:
- Clock and reset: one clock, iclk. Reset irst_n is asynchronous, active-low.
- Reset values, applied immediately on irst_n low regardless of iclk:
  - ovalid=0, ogrant=0, osel=0, ocount=0, state=IDLE.
  - Round-robin pointer last=3, so requester 0 has top priority first.
  - oack=0, since it is gated by ovalid.
- Reset mid-transfer abandons the grant with no ack. The requester keeps ireq high and is re-arbitrated after reset release.
- State machine, 2 states:
  - IDLE: ovalid=0, ogrant=0.
  - BUSY: ovalid=1, ogrant=onehot(osel).
- Arbitration (combinational, on ireq):
  - Search order is last+1, last+2, last+3, last (mod 4).
  - The winner is the first index with ireq set.
- Transitions:
  - IDLE with ireq!=0: next edge loads osel=winner, ogrant=onehot(winner), state→BUSY. Latency is ireq high → ovalid high after 1 edge.
  - IDLE with ireq==0: remain IDLE.
  - BUSY with iready=0: hold osel, ogrant, ovalid unchanged (stall).
  - BUSY with iready=1 (transfer cycle):
    - oack[osel]=1 combinationally in that cycle.
    - At the edge: last←osel, ocount←ocount+1 (wraps 2^CW-1→0).
    - Arbitration reruns with the updated priority on ireq, masking the just-acked bit.
    - If any other ireq is set: load the new grant, stay BUSY. Zero-bubble back-to-back.
    - Else: go IDLE.
- Re-grant rule: the acked requester may keep ireq high to present its next word. It competes again from the cycle after the ack, at lowest priority. A sole requester therefore streams with one idle cycle between words.
- Data path:
  - oz = ic<osel> when ovalid=1, else all zeros.
  - The requester must hold ic<n> and ireq[n] stable while ogrant[n]=1 until oack[n].
- Protocol violation: ireq[osel] dropping during BUSY does not release the grant. Transfer completes on iready.
- oack is never asserted when ovalid=0. At most one oack bit is set in any cycle.
- ireq changes during BUSY affect only the next arbitration, never the current grant.

Test Plan:
- Reset, then ireq=4'b0001, ic0=4'hA, iready=1 → after edge 1: ovalid=1, osel=0, ogrant=0001, oz=A. Same cycle oack=0001. Next edge: ovalid=0, ocount=1.
- ireq=4'b1111 held, distinct data 1/2/3/4, iready=1 → grant order 0,1,2,3,0 on consecutive cycles, no bubbles. ocount=5 after 5 transfers.
- Grant to 2 with iready=0 for 3 cycles, ireq changing to 1011 meanwhile → osel=2, oz=ic2, oack=0 throughout. First iready=1 cycle gives oack=0100, then next grant=3.
- Sole requester 1 streaming 3 words with iready=1 → ovalid pattern 1,0,1,0,1. oack[1] pulses each valid cycle.
- Assert irst_n=0 asynchronously mid-BUSY → ovalid, ogrant, oack go 0 immediately. ocount=0, last=3. After release with ireq=1010 → grant goes to 1.
- CW=2, 5 transfers → ocount sequence 1,2,3,0,1.
